// File: rtl/fpga_cfg_loader.sv
// Scan-chain configuration loader: byte handshake in, LSB-first serial
// stream plus generated prog_clk out, fabric held in reset until loaded.
module fpga_cfg_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int CLK_DIV   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       ccff_tail,
    output logic       prog_clk,
    output logic       ccff_head,
    output logic       fabric_rst,
    output logic       busy,
    output logic       done,
    output logic [7:0] tail_byte
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int PW = $clog2(2 * CLK_DIV);

    localparam logic [PW-1:0] RISE_AT  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] FALL_AT  = PW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic [PW-1:0] phase;
    logic [CW-1:0] bits_sent;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            phase      <= '0;
            bits_sent  <= '0;
            prog_clk   <= 1'b0;
            ccff_head  <= 1'b0;
            fabric_rst <= 1'b1;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tail_byte  <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        bits_sent  <= '0;
                        tail_byte  <= '0;
                        fabric_rst <= 1'b1;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        state     <= SHIFT;
                        shreg     <= in_data;
                        ccff_head <= in_data[0];
                        bit_idx   <= '0;
                        phase     <= '0;
                        in_ready  <= 1'b0;
                    end
                end
                SHIFT: begin
                    phase <= phase + 1'b1;
                    // tail is sampled on the same edge prog_clk rises,
                    // i.e. before the fabric shifts its chain
                    if (phase == RISE_AT) begin
                        prog_clk  <= 1'b1;
                        tail_byte <= {ccff_tail, tail_byte[7:1]};
                    end
                    if (phase == FALL_AT) begin
                        prog_clk  <= 1'b0;
                        phase     <= '0;
                        bits_sent <= bits_sent + 1'b1;
                        if (bits_sent == LAST_BIT) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            fabric_rst <= 1'b0;
                        end else if (bit_idx == 3'd7) begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shreg     <= shreg >> 1;
                            ccff_head <= shreg[1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: three instances (16/2, 12/2, 8/1) driven
// by directed and random loads, checked against a bit-stream model.
module tb_fpga_cfg_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] st, vl, rdy, tl, pc, hd, fr, bz, dn;
    logic [7:0] data [3];
    logic [7:0] tbq  [3];

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    fpga_cfg_loader #(.CHAIN_LEN(16), .CLK_DIV(2)) u16 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .in_data(data[0]),
        .in_valid(vl[0]), .in_ready(rdy[0]), .ccff_tail(tl[0]),
        .prog_clk(pc[0]), .ccff_head(hd[0]), .fabric_rst(fr[0]),
        .busy(bz[0]), .done(dn[0]), .tail_byte(tbq[0])
    );

    fpga_cfg_loader #(.CHAIN_LEN(12), .CLK_DIV(2)) u12 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .in_data(data[1]),
        .in_valid(vl[1]), .in_ready(rdy[1]), .ccff_tail(tl[1]),
        .prog_clk(pc[1]), .ccff_head(hd[1]), .fabric_rst(fr[1]),
        .busy(bz[1]), .done(dn[1]), .tail_byte(tbq[1])
    );

    fpga_cfg_loader #(.CHAIN_LEN(8), .CLK_DIV(1)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .in_data(data[2]),
        .in_valid(vl[2]), .in_ready(rdy[2]), .ccff_tail(tl[2]),
        .prog_clk(pc[2]), .ccff_head(hd[2]), .fabric_rst(fr[2]),
        .busy(bz[2]), .done(dn[2]), .tail_byte(tbq[2])
    );

    // Behavioural 16-bit fabric chain behind u16, clocked by prog_clk
    logic [15:0] fchain = '0;
    always @(posedge pc[0]) fchain <= {hd[0], fchain[15:1]};
    assign tl = {1'b0, 1'b1, fchain[0]};

    // Rise log: head value and cycle of every prog_clk rising edge
    logic       rh [3][1024];
    int         rc [3][1024];
    int         nr [3] = '{0, 0, 0};
    int         done_cyc [3] = '{0, 0, 0};
    logic [2:0] pcq = '0;
    logic [2:0] dnq = '0;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (pc[k] && !pcq[k] && nr[k] < 1024) begin
                rh[k][nr[k]] = hd[k];
                rc[k][nr[k]] = cyc;
                nr[k] = nr[k] + 1;
            end
            if (dn[k] && !dnq[k]) done_cyc[k] = cyc;
        end
        pcq = pc;
        dnq = dn;
    end

    function automatic int clen(input int k);
        return (k == 0) ? 16 : (k == 1) ? 12 : 8;
    endfunction

    function automatic int cdiv(input int k);
        return (k == 2) ? 1 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input int k, input string tag);
        chk({tag, ".prog_clk"}, 32'(pc[k]), 0);
        chk({tag, ".head"}, 32'(hd[k]), 0);
        chk({tag, ".fabric_rst"}, 32'(fr[k]), 1);
        chk({tag, ".busy"}, 32'(bz[k]), 0);
        chk({tag, ".done"}, 32'(dn[k]), 0);
        chk({tag, ".in_ready"}, 32'(rdy[k]), 0);
        chk({tag, ".tail_byte"}, 32'(tbq[k]), 0);
    endtask

    task automatic do_start(input int k);
        st[k] = 1'b1;
        tick();
        st[k] = 1'b0;
    endtask

    task automatic feed(input int k, input logic [7:0] b, input int gap,
                        output int acc);
        int n = 0;
        int ok = 1;
        while (!rdy[k] && n < 200) begin
            tick();
            n++;
        end
        chk("feed.ready", 32'(rdy[k]), 1);
        if (gap > 0) begin
            vl[k] = 1'b0;
            for (int g = 0; g < gap; g++) begin
                tick();
                if (rdy[k] !== 1'b1 || pc[k] !== 1'b0) ok = 0;
            end
            chk("gap.idle", ok, 1);
        end
        data[k] = b;
        vl[k] = 1'b1;
        tick();
        acc = cyc;
    endtask

    task automatic wait_done(input int k);
        int n = 0;
        while (!dn[k] && n < 400) begin
            tick();
            n++;
        end
        chk("done.timeout", 32'(dn[k]), 1);
        tick();
    endtask

    // Expected stream: bit i of the load is bit (i%8) of byte i/8
    task automatic check_load(input int k, input logic [7:0] b [4],
                              input int base, input string tag);
        int L = clen(k);
        int D = cdiv(k);
        logic [31:0] obs = '0;
        logic [31:0] exp = '0;
        int sp_ok = 1;
        chk({tag, ".rises"}, nr[k] - base, L);
        for (int i = 0; i < L; i++) begin
            obs[i] = rh[k][base + i];
            exp[i] = b[i / 8][i % 8];
        end
        chk({tag, ".heads"}, obs, exp);
        for (int i = 0; i < L - 1; i++)
            if (i % 8 != 7 && rc[k][base + i + 1] - rc[k][base + i] != 2 * D)
                sp_ok = 0;
        chk({tag, ".spacing"}, sp_ok, 1);
        chk({tag, ".done_lat"}, done_cyc[k] - rc[k][base + L - 1], D);
        chk({tag, ".done"}, 32'(dn[k]), 1);
        chk({tag, ".fabric_rst"}, 32'(fr[k]), 0);
        chk({tag, ".prog_clk"}, 32'(pc[k]), 0);
    endtask

    initial begin
        logic [7:0] bb [4];
        int base;
        int acc;
        logic [7:0] prev;
        int gap;

        rst_n = 1'b0;
        st = '0;
        vl = '0;
        for (int k = 0; k < 3; k++) data[k] = '0;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) chk_reset(k, "por");
        rst_n = 1'b1;
        tick();

        // 1: reset in the middle of a shift with prog_clk high
        do_start(0);
        feed(0, 8'hA5, 0, acc);
        tick();
        tick();
        chk("t1.pc_high", 32'(pc[0]), 1);
        rst_n = 1'b0;
        tick();
        chk_reset(0, "t1");
        tick();
        tick();
        rst_n = 1'b1;
        vl[0] = 1'b0;
        tick();
        chk("t1.idle_busy", 32'(bz[0]), 0);

        // 2: back-to-back bytes
        bb = '{8'hA5, 8'h3C, 8'h00, 8'h00};
        base = nr[0];
        do_start(0);
        feed(0, 8'hA5, 0, acc);
        feed(0, 8'h3C, 0, acc);
        wait_done(0);
        check_load(0, bb, base, "t2");
        chk("t2.chain", 32'(fchain), 32'h3CA5);

        // 3: 10-cycle in_valid gap between bytes
        base = nr[0];
        do_start(0);
        feed(0, 8'hA5, 0, acc);
        feed(0, 8'h3C, 10, acc);
        wait_done(0);
        check_load(0, bb, base, "t3");
        chk("t3.chain", 32'(fchain), 32'h3CA5);

        // 5: loopback through the fabric chain, start ignored when busy
        bb = '{8'h5A, 8'hC3, 8'h00, 8'h00};
        base = nr[0];
        do_start(0);
        feed(0, 8'h5A, 0, acc);
        tick();
        do_start(0);
        chk("t5.busy_kept", 32'(bz[0]), 1);
        chk("t5.no_restart", 32'(rdy[0]), 0);
        feed(0, 8'hC3, 0, acc);
        wait_done(0);
        check_load(0, bb, base, "t5a");
        bb = '{8'h00, 8'h00, 8'h00, 8'h00};
        base = nr[0];
        do_start(0);
        chk("t5.done_drop", 32'(dn[0]), 0);
        chk("t5.frst_up", 32'(fr[0]), 1);
        chk("t5.ready_up", 32'(rdy[0]), 1);
        feed(0, 8'h00, 0, acc);
        feed(0, 8'h00, 0, acc);
        wait_done(0);
        check_load(0, bb, base, "t5b");
        chk("t5.tail", 32'(tbq[0]), 32'hC3);

        // random loads on the 16-bit chain
        prev = 8'h00;
        for (int r = 0; r < 4; r++) begin
            bb[0] = 8'($urandom);
            bb[1] = 8'($urandom);
            gap = int'($urandom_range(0, 5));
            base = nr[0];
            do_start(0);
            feed(0, bb[0], gap, acc);
            feed(0, bb[1], gap, acc);
            wait_done(0);
            check_load(0, bb, base, "rnd16");
            chk("rnd16.chain", 32'(fchain), {16'h0, bb[1], bb[0]});
            chk("rnd16.tail", 32'(tbq[0]), 32'(prev));
            prev = bb[1];
        end

        // 4: 12-bit chain, third byte never taken
        bb = '{8'hFF, 8'h0F, 8'hAA, 8'h00};
        base = nr[1];
        do_start(1);
        feed(1, 8'hFF, 0, acc);
        feed(1, 8'h0F, 0, acc);
        data[1] = 8'hAA;
        wait_done(1);
        check_load(1, bb, base, "t4");
        repeat (5) tick();
        chk("t4.no_ready", 32'(rdy[1]), 0);
        chk("t4.rises_held", nr[1] - base, 12);
        chk("t4.tail", 32'(tbq[1]), 32'hFF);
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 3; j++) bb[j] = 8'($urandom);
            base = nr[1];
            do_start(1);
            feed(1, bb[0], 0, acc);
            feed(1, bb[1], int'($urandom_range(0, 3)), acc);
            wait_done(1);
            check_load(1, bb, base, "rnd12");
        end

        // 6: CLK_DIV=1, single byte
        bb = '{8'h81, 8'h00, 8'h00, 8'h00};
        base = nr[2];
        do_start(2);
        feed(2, 8'h81, 0, acc);
        wait_done(2);
        check_load(2, bb, base, "t6");
        chk("t6.done_after_acc", done_cyc[2] - acc, 16);
        chk("t6.tail", 32'(tbq[2]), 0);
        for (int r = 0; r < 2; r++) begin
            bb[0] = 8'($urandom);
            base = nr[2];
            do_start(2);
            feed(2, bb[0], int'($urandom_range(0, 3)), acc);
            wait_done(2);
            check_load(2, bb, base, "rnd8");
            chk("rnd8.done_after_acc", done_cyc[2] - acc, 16);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
